// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front-end.
// Entry format pairs each fetched instruction with the PC it was fetched from.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO with synchronous flush; head is read combinationally, 1-cycle write-to-visible.
// Pushes when full and pops when empty are ignored; flush wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rptr[AW-1:0]];
  assign o_count    = CW'(r_wptr - r_rptr);

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, in-order instruction queue to decode.
// Request accept N -> response N+1 -> inst_valid N+2; redirects flush and drop in-flight responses.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_q_count;
  logic [CW-1:0]   w_pcq_count;
  logic [CW:0]     w_inflight;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_resp_keep;
  logic            w_q_empty;
  logic            w_q_pop;
  logic [XLEN-1:0] w_req_pc;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic            w_unused;

  // Reserving a queue slot per outstanding request guarantees every kept response has room.
  assign w_inflight     = {1'b0, w_q_count} + {1'b0, r_outstanding};
  assign w_credit       = w_inflight < (CW+1)'(DEPTH);
  assign imem_req_valid = rst_n && !redirect_valid && w_credit;
  assign imem_addr      = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_resp_keep    = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0);

  assign w_q_empty    = (w_q_count == '0);
  assign inst_valid   = !w_q_empty;
  assign w_q_pop      = inst_valid && inst_ready;
  assign inst         = w_q_empty ? '0 : w_head.inst;
  assign inst_pc      = w_q_empty ? '0 : w_head.pc;
  assign w_push_entry = '{inst: imem_resp_data, pc: w_req_pc};
  assign w_unused     = ^w_pcq_count;

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (redirect_valid),
    .i_push     (w_resp_keep),
    .i_push_dat (w_push_entry),
    .i_pop      (w_q_pop),
    .o_head_dat (w_head),
    .o_count    (w_q_count)
  );

  // Holds the PC of each non-dropped request until its response returns.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (redirect_valid),
    .i_push     (w_req_fire),
    .i_push_dat (r_pc),
    .i_pop      (w_resp_keep),
    .o_head_dat (w_req_pc),
    .o_count    (w_pcq_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the squashed path.
      r_pc          <= align_word(redirect_pc);
      r_outstanding <= r_outstanding - CW'(imem_resp_valid);
      r_drop_cnt    <= r_outstanding - CW'(imem_resp_valid);
    end else begin
      if (w_req_fire) r_pc <= r_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: behavioural instruction memory, expected-stream scoreboard, negedge monitor.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  always #5 clk = ~clk;

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;

  exp_t  exp_q[$];
  mreq_t pend[$];
  exp_t  m_e;
  int    n_cmp = 0, n_err = 0, n_pop = 0, cyc = 0, lat = 1;
  bit    hold = 1'b0;
  bit    m_fire, m_resp;
  logic [31:0] m_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 48; i++)
      exp_q.push_back('{pc: start + 32'(4*i), inst: mem_word(start + 32'(4*i))});
  endtask

  task automatic present();
    if (!rst_n || hold || pend.size() == 0 || pend[0].due > 32'(cyc)) begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Memory: in-order responses, lat cycles after accept; stale requests vanish on reset.
  always @(posedge clk) begin
    m_fire = imem_req_valid && imem_req_ready;
    m_addr = imem_addr;
    m_resp = imem_resp_valid;
    #1;
    cyc++;
    if (!rst_n) pend.delete();
    else begin
      if (m_resp && pend.size() > 0) pend.delete(0);
      if (m_fire) pend.push_back('{addr: m_addr, due: 32'(cyc + lat - 1)});
    end
    present();
  end

  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %h, expected no output", inst_pc);
      end else begin
        m_e = exp_q.pop_front();
        check("inst_pc", inst_pc, m_e.pc);
        check("inst", inst, m_e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n_wait, p;
    rst_n = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    tick(2);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // Straight line from RESET_PC, memory latency 1
    expect_stream(32'h0);
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    rst_n = 1'b1;
    n_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) break;
      n_wait++;
    end
    check("first_valid_cycle", 32'(n_wait), 32'd2);
    tick(1);
    p = n_pop;
    tick(8);
    check("sustained_rate", 32'(n_pop - p), 32'd8);

    // Backpressure: queue saturates, requests stop, nothing lost on release
    inst_ready = 1'b0;
    tick(10);
    #1;
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check("bp_inst_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    tick(6);

    // Redirect to 0x100 with one queued entry and two responses in flight
    imem_req_ready = 1'b0;
    tick(4);
    inst_ready = 1'b0; imem_req_ready = 1'b1;
    tick(1);
    imem_req_ready = 1'b0;
    tick(3);
    hold = 1'b1; present();
    imem_req_ready = 1'b1;
    tick(2);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("r1_queued_before", 32'(inst_valid), 32'd1);
    check("r1_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    expect_stream(32'h100);
    #2;
    redirect_valid = 1'b0;
    #1;
    check("r1_empty_after", 32'(inst_valid), 32'd0);
    check("r1_addr", imem_addr, 32'h100);
    hold = 1'b0; present();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    p = n_pop;
    tick(8);
    check("r1_progress", 32'(n_pop - p >= 3), 32'd1);

    // Redirect to 0x203 coincident with a response, memory latency 2
    lat = 2;
    tick(6);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(posedge clk);
    expect_stream(32'h200);
    #2;
    redirect_valid = 1'b0;
    #1;
    check("r2_addr_aligned", imem_addr, 32'h200);
    p = n_pop;
    tick(10);
    check("r2_progress", 32'(n_pop - p >= 3), 32'd1);

    // Back-to-back redirects: 0x40 then 0x80
    lat = 1;
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(posedge clk);
    expect_stream(32'h40);
    #2;
    redirect_pc = 32'h80;
    @(posedge clk);
    expect_stream(32'h80);
    #2;
    redirect_valid = 1'b0;
    #1;
    check("r3_addr", imem_addr, 32'h80);
    p = n_pop;
    tick(8);
    check("r3_progress", 32'(n_pop - p >= 3), 32'd1);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    present();
    #1;
    check("ar_req_valid", 32'(imem_req_valid), 32'd0);
    check("ar_inst_valid", 32'(inst_valid), 32'd0);
    check("ar_inst", inst, 32'd0);
    check("ar_inst_pc", inst_pc, 32'd0);
    expect_stream(32'h0);
    tick(2);
    rst_n = 1'b1;
    #1;
    check("ar_first_req", 32'(imem_req_valid), 32'd1);
    check("ar_first_addr", imem_addr, 32'h0);
    p = n_pop;
    tick(8);
    check("ar_progress", 32'(n_pop - p >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
